// File: rtl/comparator_sort_ctrl.sv
// Burst sorter: loads DEPTH words, bubble-sorts them in place through one shared
// 4-bit magnitude comparator (one compare per cycle), then streams them out in order.

module comparator #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less
);
  assign A_greater = (A > B);
  assign A_equal   = (A == B);
  assign A_less    = (A < B);
endmodule

module comparator_sort_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [7:0]       swap_cnt
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_CMP = IDX_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SORT,
    ST_UNLOAD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] p_q, p_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [7:0]       swap_cnt_q, swap_cnt_d;

  logic [IDX_W-1:0] j_nx;
  logic             a_gt, a_eq, a_lt;
  logic             do_swap;

  assign j_nx = j_q + IDX_W'(1);

  comparator #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .A        (mem_q[j_q]),
    .B        (mem_q[j_nx]),
    .A_greater(a_gt),
    .A_equal  (a_eq),
    .A_less   (a_lt)
  );

  // Equal neighbours never trade places, which keeps the sort stable.
  assign do_swap = !a_eq && ((DESCEND != 0) ? a_lt : a_gt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      p_q        <= '0;
      j_q        <= '0;
      swap_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      p_q        <= p_d;
      j_q        <= j_d;
      swap_cnt_q <= swap_cnt_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    p_d        = p_q;
    j_d        = j_q;
    swap_cnt_d = swap_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == LAST_IDX) begin
            state_d    = ST_SORT;
            wr_idx_d   = '0;
            swap_cnt_d = '0;
            p_d        = '0;
            j_d        = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end

      // Fixed (DEPTH-1)^2 compare schedule; no early exit even if already sorted.
      ST_SORT: begin
        busy = 1'b1;
        if (do_swap) begin
          mem_d[j_q]  = mem_q[j_nx];
          mem_d[j_nx] = mem_q[j_q];
          swap_cnt_d  = swap_cnt_q + 8'd1;
        end
        if (j_q == LAST_CMP) begin
          j_d = '0;
          if (p_q == LAST_CMP) begin
            state_d  = ST_UNLOAD;
            p_d      = '0;
            rd_idx_d = '0;
          end else begin
            p_d = p_q + IDX_W'(1);
          end
        end else begin
          j_d = j_nx;
        end
      end

      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = ST_LOAD;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign out_data = mem_q[rd_idx_q];
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Bench for comparator_sort_ctrl: an ascending and a descending instance driven with
// identical streams, checked against fixed vectors and a stable-sort/inversion-count model.

module tb_comparator_sort_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       in_ready_a, out_valid_a, busy_a;
  logic [3:0] out_data_a;
  logic [7:0] swap_a;
  logic       in_ready_d, out_valid_d, busy_d;
  logic [3:0] out_data_d;
  logic [7:0] swap_d;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_sw_a = 8'd0;
  logic [7:0] exp_sw_d = 8'd0;

  typedef logic [3:0][3:0] burst_t;
  typedef struct {
    burst_t din;
    burst_t asc;
    burst_t desc;
    int     sw_a;
    int     sw_d;
  } vec_t;

  always #5 clk = ~clk;

  comparator_sort_ctrl #(.WIDTH(4), .DEPTH(4), .DESCEND(0)) u_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .swap_cnt(swap_a)
  );

  comparator_sort_ctrl #(.WIDTH(4), .DEPTH(4), .DESCEND(1)) u_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .busy(busy_d), .swap_cnt(swap_d)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic burst_t mk(input int a, input int b, input int c, input int d);
    burst_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d);
    return r;
  endfunction

  // Stable sort of the burst values (insertion into an ordered prefix).
  function automatic burst_t model_sort(input burst_t d, input bit desc);
    burst_t r = d;
    logic [3:0] t;
    for (int i = 1; i < 4; i++) begin
      for (int k = i; k > 0; k--) begin
        if (desc ? (r[k] > r[k-1]) : (r[k] < r[k-1])) begin
          t = r[k]; r[k] = r[k-1]; r[k-1] = t;
        end
      end
    end
    return r;
  endfunction

  // Bubble sort performs exactly one swap per out-of-order pair.
  function automatic int model_swaps(input burst_t d, input bit desc);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = i + 1; k < 4; k++) begin
        if (desc ? (d[i] < d[k]) : (d[i] > d[k])) n++;
      end
    end
    return n;
  endfunction

  task automatic load_burst(input burst_t d, input int stall_pct);
    int idx = 0;
    int guard = 0;
    bit bad = 1'b0;
    bit acc;
    while (idx < 4 && guard < 200) begin
      in_data  = d[idx];
      in_valid = ($urandom_range(99) >= stall_pct);
      if (in_ready_a !== 1'b1 || in_ready_d !== 1'b1 || out_valid_a !== 1'b0) bad = 1'b1;
      if (swap_a !== exp_sw_a || swap_d !== exp_sw_d) bad = 1'b1;
      acc = in_valid && in_ready_a;
      tick();
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("load_words", idx, 4);
    chk("load_ready_and_swap_hold", bad, 0);
    chk("sort_entry_swap_a", swap_a, 0);
    chk("sort_entry_swap_d", swap_d, 0);
  endtask

  task automatic sort_wait();
    int cyc = 0;
    bit bad = 1'b0;
    while (busy_a === 1'b1 && cyc < 40) begin
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || busy_d !== 1'b1) bad = 1'b1;
      in_valid = $urandom_range(1);
      in_data  = 4'($urandom_range(15));
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    chk("sort_cycles", cyc, 9);
    chk("sort_flags", bad, 0);
    chk("first_out_valid", out_valid_a, 1);
  endtask

  task automatic unload_burst(input burst_t ea, input burst_t ed, input int sw_a, input int sw_d,
                              input int ready_pct, input bit offer, input logic [3:0] offer_word);
    int idx = 0;
    int guard = 0;
    bit bad = 1'b0;
    bit stalled = 1'b0;
    logic [3:0] prev = 4'd0;
    chk("unload_swap_a", swap_a, sw_a);
    chk("unload_swap_d", swap_d, sw_d);
    exp_sw_a = 8'(sw_a);
    exp_sw_d = 8'(sw_d);
    if (offer) begin
      in_valid = 1'b1;
      in_data  = offer_word;
    end
    while (idx < 4 && guard < 200) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid_a !== 1'b1 || out_valid_d !== 1'b1 || in_ready_a !== 1'b0 ||
          in_ready_d !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
      if (stalled && out_data_a !== prev) bad = 1'b1;
      if (out_ready) begin
        chk("out_data_asc", out_data_a, ea[idx]);
        chk("out_data_desc", out_data_d, ed[idx]);
        idx++;
      end
      stalled = !out_ready;
      prev    = out_data_a;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    chk("unload_words", idx, 4);
    chk("unload_flags", bad, 0);
    chk("after_unload_out_valid", out_valid_a, 0);
    chk("after_unload_in_ready", in_ready_a, 1);
  endtask

  task automatic run_vec(input vec_t v, input int stall_pct, input int ready_pct,
                         input bit offer, input logic [3:0] offer_word);
    load_burst(v.din, stall_pct);
    sort_wait();
    unload_burst(v.asc, v.desc, v.sw_a, v.sw_d, ready_pct, offer, offer_word);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_swap_a", swap_a, 0);
    chk("rst_swap_d", swap_d, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    exp_sw_a = 8'd0;
    exp_sw_d = 8'd0;
    chk("post_rst_in_ready", in_ready_a, 1);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{mk(9, 6, 14, 0),    mk(0, 6, 9, 14),    mk(14, 9, 6, 0),    4, 2};
    tbl[1] = '{mk(10, 10, 5, 10),  mk(5, 10, 10, 10),  mk(10, 10, 10, 5),  2, 1};
    tbl[2] = '{mk(15, 10, 5, 0),   mk(0, 5, 10, 15),   mk(15, 10, 5, 0),   6, 0};
    tbl[3] = '{mk(3, 12, 7, 12),   mk(3, 7, 12, 12),   mk(12, 12, 7, 3),   1, 4};
    tbl[4] = '{mk(1, 2, 3, 4),     mk(1, 2, 3, 4),     mk(4, 3, 2, 1),     0, 6};

    #2;
    apply_reset();

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], 0, 100, 1'b0, 4'd0);
    end

    // Backpressure: first sorted word is 0; it must hold while out_ready stays low.
    load_burst(tbl[0].din, 50);
    sort_wait();
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_data", out_data_a, 0);
      chk("stall_out_valid", out_valid_a, 1);
      tick();
    end
    unload_burst(tbl[0].asc, tbl[0].desc, 4, 2, 50, 1'b0, 4'd0);

    // Reset in the 4th SORT cycle, then a clean burst.
    load_burst(tbl[2].din, 0);
    repeat (3) tick();
    chk("mid_sort_busy", busy_a, 1);
    apply_reset();
    run_vec(tbl[4], 0, 100, 1'b0, 4'd0);

    // Reset during UNLOAD drops out_valid without waiting for a clock edge.
    load_burst(tbl[3].din, 0);
    sort_wait();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid_a, 0);
    chk("async_rst_out_valid_d", out_valid_d, 0);
    apply_reset();

    // Back-to-back: next burst offered during unload, swap_cnt held across LOAD.
    run_vec(tbl[0], 0, 100, 1'b1, tbl[1].din[0]);
    run_vec(tbl[1], 0, 100, 1'b0, 4'd0);

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 4; k++) rv.din[k] = 4'($urandom_range(15));
      rv.asc  = model_sort(rv.din, 1'b0);
      rv.desc = model_sort(rv.din, 1'b1);
      rv.sw_a = model_swaps(rv.din, 1'b0);
      rv.sw_d = model_swaps(rv.din, 1'b1);
      run_vec(rv, $urandom_range(60), 40 + $urandom_range(60), 1'($urandom_range(1)),
              4'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_sort_ctrl.md
Name: comparator_sort_ctrl

Overview:
Sequencer that time-shares one 4-bit `comparator` instance (ports A, B, A_greater, A_equal, A_less) to sort a fixed-size burst of words.
- Loads DEPTH words through a valid/ready input stream.
- Bubble-sorts them in place, issuing one comparison per cycle.
- Unloads the sorted words through a valid/ready output stream.
- Sits between a sample producer and a downstream consumer that needs ordered values.

Parameters:
WIDTH, 4, data word width; must match the comparator; only 4 is supported.
DEPTH, 4, words per burst; legal range 2..16.
DESCEND, 0, 0 = ascending order (swap on A_greater); 1 = descending order (swap on A_less).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a word this cycle
in_data  input  WIDTH  input word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  sorted word
busy  output  1  high in SORT state
swap_cnt  output  8  swaps performed in the current burst

Behaviour:
- Reset (async assert, any state): state=LOAD, all mem entries=0, counters=0, swap_cnt=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset deasserts. A burst in progress is discarded.
- States: LOAD, SORT, UNLOAD.
- LOAD:
  - in_ready=1, out_valid=0.
  - Transfer occurs when in_valid && in_ready. Word is written to mem[wr_idx]; wr_idx increments.
  - The transfer of word DEPTH-1 moves the FSM to SORT and clears wr_idx and swap_cnt. swap_cnt is cleared at LOAD→SORT only, so it holds its value through UNLOAD and the next LOAD.
- SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Fixed length: exactly (DEPTH-1)^2 cycles, i.e. 9 for DEPTH=4. There is no early exit.
  - Nested counters: pass p and index j, each 0..DEPTH-2. Each cycle the comparator sees A=mem[j], B=mem[j+1].
  - If the swap condition holds, the two entries are exchanged at the clock edge and swap_cnt increments.
  - Equal words are never swapped, so the sort is stable.
  - j wraps to 0 and p increments. The edge after p=DEPTH-2, j=DEPTH-2 enters UNLOAD with rd_idx=0.
- UNLOAD:
  - out_valid=1, out_data=mem[rd_idx]. in_ready=0; in_valid is ignored.
  - On out_valid && out_ready, rd_idx increments.
  - With out_ready low, out_data and out_valid hold stable for any number of cycles.
  - The transfer of word DEPTH-1 returns the FSM to LOAD, clears rd_idx, and drops out_valid in the next cycle.
- Latency, DEPTH=4, no backpressure: last input accepted at edge t → SORT during cycles t+1..t+9 → out_valid first high in cycle t+10.
- The comparator is instantiated exactly once. No other magnitude compare on data words exists in the block.
- Out-of-state events:
  - in_valid in SORT/UNLOAD: no effect.
  - out_ready in LOAD/SORT: no effect.

Test Plan:
1. Ascending sort: reset, load 9,6,14,0 with no stalls → busy high for exactly 9 cycles; outputs 0,6,9,14; swap_cnt=4; out_valid high 10 cycles after the last input edge.
2. Equal values and worst case: load 10,10,5,10 → outputs 5,10,10,10, swap_cnt=2. Then load 15,10,5,0 → outputs 0,5,10,15, swap_cnt=6 (max for DEPTH=4).
3. DESCEND=1: load 3,12,7,12 → outputs 12,12,7,3; swap_cnt=4.
4. Handshake backpressure: toggle in_valid randomly during LOAD; hold out_ready low 5 cycles with out_data=0 → out_data stays 0. Then pulse out_ready → one word per pulse, order preserved; in_ready=0 throughout UNLOAD.
5. Reset mid-operation: assert rst during the 4th SORT cycle, release, then load 1,2,3,4 → outputs 1,2,3,4, swap_cnt=0, no stale data. Also assert rst mid-UNLOAD → out_valid=0 immediately (asynchronous).
6. Back-to-back bursts: offer the next burst's words while the last output word transfers → no input accepted before LOAD; the second burst sorts correctly, and swap_cnt holds the first burst's value until the second burst's LOAD→SORT transition.
